fb_write_ctrl: RTL
==================

Name: fb_write_ctrl

Overview:
- Parametrised SPI-to-framebuffer write bridge; the successor to the fixed 8000-byte write logic in the top level.
- Sits between spi_slave (rxbuf/dr) and the framebuffer write port.
- Synchronises the byte-ready strobe into the system clock, buffers one byte, and generates the framebuffer write strobe and address.
- Requests a buffer swap at end of frame; an optional mode waits for an LCD-side acknowledge before the next frame starts.

Parameters:
- ADDR_W, 32, width of fb_waddr.
- FRAME_BYTES, 8000, bytes per frame; address wraps after FRAME_BYTES-1.
- SYNC_STAGES, 2, flop stages on rx_dr, sof and swap_ack (minimum 2).

Ports:
- clk  in  1  system clock; all logic on negedge clk, matching the top level.
- rst_n  in  1  asynchronous active-low reset.
- rx_dr  in  1  byte-ready from spi_slave; asynchronous; high while rx_byte is valid.
- rx_byte  in  8  received byte; stable while rx_dr is high.
- sof  in  1  asynchronous start-of-frame request (e.g. CS edge); level, edge-detected.
- swap_ack  in  1  asynchronous swap acknowledge from the LCD side; ignored unless FBW_SWAP_ACK_EN.
- ovr_clr  in  1  synchronous pulse; clears overrun.
- fb_wclk  out  1  framebuffer write clock; the write occurs on its rising edge.
- fb_waddr  out  ADDR_W  write address.
- fb_wdata  out  8  write data.
- fb_switch  out  1  buffer swap request.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky: a byte was dropped.
- frame_cnt  out  8  completed frames, wraps at 255->0.

Behaviour:
- Reset values: fb_wclk=1, fb_waddr=0, fb_wdata=0, fb_switch=0, overrun=0, frame_cnt=0, pending=0, state=IDLE.
- rx_dr, sof and swap_ack each pass through SYNC_STAGES flops. A rising edge of synced rx_dr or synced sof is a one-cycle event.
- Byte event: rx_byte is sampled directly in the event cycle into a one-entry hold register, and pending is set.
  - If pending is already set, or state is SWAP, the byte is dropped and overrun is set.
- FSM states: IDLE, SETUP, STROBE, SWAP.
  - IDLE: if pending -> SETUP. fb_wdata <= hold register, fb_wclk <= 0, pending cleared.
  - SETUP (1 cycle): fb_wclk=0, address and data stable -> STROBE. fb_wclk <= 1.
  - STROBE (1 cycle): rising fb_wclk writes the byte.
    - If fb_waddr == FRAME_BYTES-1: fb_waddr <= 0, frame_cnt++, go to SWAP.
    - Otherwise fb_waddr++ and go to IDLE.
  - SWAP, without ACK mode: fb_switch=1 for exactly one cycle, then IDLE.
- Latency: write rising edge occurs 3 clk cycles after the synced rx_dr edge when the FSM is idle. Back-to-back bytes are accepted at one per 3 cycles.
- sof event:
  - In IDLE: fb_waddr <= 0 immediately.
  - In SETUP/STROBE: latched and applied at STROBE exit, overriding the increment.
  - In SWAP: no effect, since the address is already 0.
  - sof never triggers a swap and does not count a frame.
- Simultaneous wrap and sof: wrap wins (swap issued; address is 0 either way).
- Simultaneous byte event and ovr_clr: overrun ends set.
- Reset mid-write: all outputs return to reset values asynchronously. The partial frame is discarded and no swap is issued.

Optional Feature:
- FBW_SWAP_ACK_EN defined:
  - SWAP holds fb_switch=1 until synced swap_ack is seen high, then fb_switch <= 0 and the FSM goes to IDLE.
  - Bytes arriving while in SWAP are dropped and set overrun.
- FBW_SWAP_ACK_EN undefined:
  - SWAP issues a one-cycle pulse.
  - swap_ack is unused and its synchroniser is not built.

Decomposition:
- Package fb_pkg: state encoding constants (IDLE/SETUP/STROBE/SWAP) and the default FRAME_BYTES.
- One sub-module: sync_edge (SYNC_STAGES flop chain plus rising-edge pulse), instantiated for rx_dr, sof and, when enabled, swap_ack.

Test Plan:
- Single byte 0xA5 after reset -> fb_wclk low with fb_wdata=0xA5 and fb_waddr=0, rises 3 cycles after the synced edge; fb_waddr=1 afterwards.
- FRAME_BYTES=4, send 4 bytes -> writes at addresses 0..3, one-cycle fb_switch after the 4th, frame_cnt=1, fb_waddr=0.
- Two rx_dr edges 1 cycle apart (synced) -> both written to consecutive addresses. A third edge within the same write window -> dropped, overrun=1. Then ovr_clr -> overrun=0.
- sof after 2 bytes, FRAME_BYTES=4 -> next byte written to address 0, no fb_switch, frame_cnt unchanged.
- FBW_SWAP_ACK_EN, FRAME_BYTES=2 -> fb_switch stays high until swap_ack; a byte sent meanwhile is dropped (overrun=1). After ack, the next byte goes to address 0.
- rst_n low during STROBE -> fb_wclk=1, fb_waddr=0, fb_switch=0 immediately; the first byte after release is written to address 0.

Source files
------------

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the SPI-to-framebuffer write bridge:
//   - fb_state_e         : write FSM state encoding (IDLE/SETUP/STROBE/SWAP)
//   - FB_ADDR_W_DEF      : default framebuffer address width
//   - FB_FRAME_BYTES_DEF : default bytes per frame
//   - FB_SYNC_STAGES_DEF : default synchroniser depth
// -----------------------------------------------------------------------------
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_SWAP   = 2'd3
    } fb_state_e;

    localparam int FB_ADDR_W_DEF      = 32;
    localparam int FB_FRAME_BYTES_DEF = 8000;
    localparam int FB_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/fb_write_ctrl_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Brings an asynchronous level into the clk domain through a STAGES-deep flop
// chain and produces a one-cycle pulse on its rising edge. Clocked on the
// falling edge of clk, like the rest of the bridge.
//
// Ports:
//   clk      in   system clock (falling edge active)
//   rst_n    in   asynchronous active-low reset
//   i_async  in   asynchronous input level
//   o_level  out  synchronised level
//   o_rise   out  one-cycle pulse on a rising edge of o_level
//
// STAGES must be at least 2.
// -----------------------------------------------------------------------------
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/fb_write_ctrl.sv
// -----------------------------------------------------------------------------
// fb_write_ctrl
// Bridge from spi_slave (rxbuf/dr) to the framebuffer write port. Synchronises
// the byte-ready strobe, buffers one byte, generates the framebuffer write
// clock and address, and requests a buffer swap at the end of every frame.
//
// Build option: define FBW_SWAP_ACK_EN to hold fb_switch high until the LCD
// side acknowledges on swap_ack. Without it fb_switch is a one-cycle pulse and
// swap_ack is ignored.
//
// Ports:
//   clk        in   system clock; all logic runs on its falling edge
//   rst_n      in   asynchronous active-low reset
//   rx_dr      in   async byte-ready from spi_slave
//   rx_byte    in   received byte, stable while rx_dr is high
//   sof        in   async start-of-frame level (edge detected)
//   swap_ack   in   async swap acknowledge (FBW_SWAP_ACK_EN only)
//   ovr_clr    in   synchronous pulse clearing overrun
//   fb_wclk    out  framebuffer write clock, write on its rising edge
//   fb_waddr   out  write address, wraps after FRAME_BYTES-1
//   fb_wdata   out  write data
//   fb_switch  out  buffer swap request
//   busy       out  FSM not in IDLE
//   overrun    out  sticky: a byte was dropped
//   frame_cnt  out  completed frames, modulo 256
// -----------------------------------------------------------------------------
module fb_write_ctrl
    import fb_pkg::*;
#(
    parameter int ADDR_W      = FB_ADDR_W_DEF,
    parameter int FRAME_BYTES = FB_FRAME_BYTES_DEF,
    parameter int SYNC_STAGES = FB_SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_dr,
    input  logic [7:0]        rx_byte,
    input  logic              sof,
    input  logic              swap_ack,
    input  logic              ovr_clr,
    output logic              fb_wclk,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic [7:0]        fb_wdata,
    output logic              fb_switch,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        frame_cnt
);

    localparam logic [ADDR_W-1:0] LP_LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

    fb_state_e         r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_fb_waddr,  w_waddr_nxt;
    logic [7:0]        r_fb_wdata,  w_wdata_nxt;
    logic [7:0]        r_frame_cnt, w_frame_nxt;
    logic              r_fb_wclk,   w_wclk_nxt;
    logic              r_fb_switch, w_switch_nxt;
    logic              r_sof_lat,   w_sof_lat_nxt;
    logic [7:0]        r_hold;
    logic              r_pending;
    logic              r_overrun;
    logic              w_take;
    logic              w_rx_ev, w_rx_lvl;
    logic              w_sof_ev, w_sof_lvl;
    logic              w_byte_drop, w_byte_acc;
    logic              w_unused_ok;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (rx_dr),
        .o_level (w_rx_lvl),
        .o_rise  (w_rx_ev)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sof (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (sof),
        .o_level (w_sof_lvl),
        .o_rise  (w_sof_ev)
    );

`ifdef FBW_SWAP_ACK_EN
    logic w_ack_lvl, w_ack_rise;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (swap_ack),
        .o_level (w_ack_lvl),
        .o_rise  (w_ack_rise)
    );

    // Synchroniser outputs the datapath has no use for.
    assign w_unused_ok = &{1'b0, w_rx_lvl, w_sof_lvl, w_ack_rise};
`else
    assign w_unused_ok = &{1'b0, w_rx_lvl, w_sof_lvl, swap_ack};
`endif

    // A byte is lost if the hold register is still full or a swap is under way.
    assign w_byte_drop = w_rx_ev & (r_pending | (r_state == ST_SWAP));
    assign w_byte_acc  = w_rx_ev & ~w_byte_drop;

    // NOTE: every variable gets its default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_wclk_nxt    = r_fb_wclk;
        w_waddr_nxt   = r_fb_waddr;
        w_wdata_nxt   = r_fb_wdata;
        w_switch_nxt  = r_fb_switch;
        w_frame_nxt   = r_frame_cnt;
        w_sof_lat_nxt = r_sof_lat;
        w_take        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_sof_ev) begin
                    w_waddr_nxt = '0;
                end
                if (r_pending) begin
                    w_wdata_nxt = r_hold;
                    w_wclk_nxt  = 1'b0;
                    w_take      = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // A frame restart here must not disturb the address being
                // written; remember it for STROBE exit.
                if (w_sof_ev) begin
                    w_sof_lat_nxt = 1'b1;
                end
                w_wclk_nxt  = 1'b1;
                w_state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                w_sof_lat_nxt = 1'b0;
                // Wrap takes precedence over a pending restart: both leave the
                // address at 0, but only the wrap completes a frame.
                if (r_fb_waddr == LP_LAST_ADDR) begin
                    w_waddr_nxt  = '0;
                    w_frame_nxt  = r_frame_cnt + 8'd1;
                    w_switch_nxt = 1'b1;
                    w_state_nxt  = ST_SWAP;
                end else begin
                    if (w_sof_ev || r_sof_lat) begin
                        w_waddr_nxt = '0;
                    end else begin
                        w_waddr_nxt = r_fb_waddr + ADDR_W'(1);
                    end
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SWAP: begin
`ifdef FBW_SWAP_ACK_EN
                if (w_ack_lvl) begin
                    w_switch_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
`else
                w_switch_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Falling-edge clocking matches the surrounding top level, which presents
    // the framebuffer write port on the opposite edge to its consumers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_fb_wclk   <= 1'b1;
            r_fb_waddr  <= '0;
            r_fb_wdata  <= '0;
            r_fb_switch <= 1'b0;
            r_frame_cnt <= '0;
            r_sof_lat   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fb_wclk   <= w_wclk_nxt;
            r_fb_waddr  <= w_waddr_nxt;
            r_fb_wdata  <= w_wdata_nxt;
            r_fb_switch <= w_switch_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_sof_lat   <= w_sof_lat_nxt;
        end
    end

    // One-entry byte buffer and overrun flag. rx_byte is sampled directly in
    // the synced event cycle; spi_slave holds it long after rx_dr rises.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold    <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_byte_acc) begin
                r_hold    <= rx_byte;
                r_pending <= 1'b1;
            end else if (w_take) begin
                r_pending <= 1'b0;
            end
            // A drop in the same cycle as ovr_clr leaves the flag set.
            if (w_byte_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign fb_wclk   = r_fb_wclk;
    assign fb_waddr  = r_fb_waddr;
    assign fb_wdata  = r_fb_wdata;
    assign fb_switch = r_fb_switch;
    assign busy      = (r_state != ST_IDLE);
    assign overrun   = r_overrun;
    assign frame_cnt = r_frame_cnt;

endmodule
